// File: rtl/run_control.sv
// Run/step/halt sequencer for the nic8 core: drives the CPU register-load enable and counts retired cycles.
// Optional PC breakpoint logic is compiled in when the BREAKPOINT_EN macro is defined.
module run_control #(
  parameter int unsigned COUNT_W      = 16,
  parameter bit          RUN_AT_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_op,
  input  logic [COUNT_W-1:0] cmd_arg,
  output logic               cmd_ready,
  input  logic [7:0]         pc,
  input  logic [7:0]         bp_addr,
  input  logic               bp_arm,
  output logic               cpu_en,
  output logic [1:0]         state,
  output logic [1:0]         halt_cause,
  output logic [COUNT_W-1:0] retired
);

  localparam int unsigned OP_W = 2;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_COUNTING = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    HC_NONE       = 2'd0,
    HC_CMD        = 2'd1,
    HC_COUNT_DONE = 2'd2,
    HC_BREAKPOINT = 2'd3
  } cause_t;

  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_RUN   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_STEP  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_RUN_N = OP_W'(3);

  localparam state_t RESET_STATE = RUN_AT_RESET ? ST_RUNNING : ST_HALTED;

  state_t               state_q, state_d;
  cause_t               cause_q, cause_d;
  logic [COUNT_W-1:0]   remaining_q, remaining_d;
  logic [COUNT_W-1:0]   retired_q;
  logic                 accept;
  logic                 bp_hit;
  logic                 last_count;

  assign cmd_ready = (state_q == ST_HALTED) || (cmd_op == OP_HALT);
  assign accept    = cmd_valid && cmd_ready;

`ifdef BREAKPOINT_EN
  logic skip_bp_q, skip_bp_d;

  // First cycle after resuming ignores a match so the breakpoint instruction itself can execute.
  assign bp_hit = bp_arm && (pc == bp_addr) && !skip_bp_q && (state_q != ST_HALTED);
  assign skip_bp_d = (state_q == ST_HALTED) && (state_d != ST_HALTED);

  always_ff @(posedge clk) begin
    if (reset) skip_bp_q <= 1'b0;
    else       skip_bp_q <= skip_bp_d;
  end
`else
  logic unused_bp;

  assign bp_hit    = 1'b0;
  assign unused_bp = ^{pc, bp_addr, bp_arm};
`endif

  // Enable depends only on registered state and pc; reset forces it low.
  assign cpu_en     = !reset && (state_q != ST_HALTED) && !bp_hit;
  assign last_count = (state_q == ST_COUNTING) && cpu_en && (remaining_q == COUNT_W'(1));

  // Next-state logic; halt cause priority is breakpoint, then count done, then command.
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    remaining_d = remaining_q;
    unique case (state_q)
      ST_HALTED: begin
        if (accept) begin
          unique case (cmd_op)
            OP_RUN: state_d = ST_RUNNING;
            OP_STEP: begin
              state_d     = ST_COUNTING;
              remaining_d = COUNT_W'(1);
            end
            OP_RUN_N: begin
              if (cmd_arg != '0) begin
                state_d     = ST_COUNTING;
                remaining_d = cmd_arg;
              end else begin
                cause_d = HC_COUNT_DONE;
              end
            end
            default: ;
          endcase
        end
      end
      ST_RUNNING, ST_COUNTING: begin
        if ((state_q == ST_COUNTING) && cpu_en) remaining_d = remaining_q - COUNT_W'(1);
        if (bp_hit) begin
          state_d     = ST_HALTED;
          cause_d     = HC_BREAKPOINT;
          remaining_d = '0;
        end else if (last_count) begin
          state_d = ST_HALTED;
          cause_d = HC_COUNT_DONE;
        end else if (accept && (cmd_op == OP_HALT)) begin
          state_d = ST_HALTED;
          cause_d = HC_CMD;
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      cause_q     <= HC_NONE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      remaining_q <= remaining_d;
    end
  end

  // Retired-cycle counter wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (reset)       retired_q <= '0;
    else if (cpu_en) retired_q <= retired_q + COUNT_W'(1);
  end

  assign state      = state_q;
  assign halt_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control: cycle-by-cycle vector table plus hand sequences for
// breakpoints, mid-count reset and retired-counter wrap.
module tb_run_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd1;
  logic [15:0] cmd_arg = '0;
  logic        cmd_ready;
  logic [7:0]  pc;
  logic [7:0]  bp_addr = 8'h00;
  logic        bp_arm = 1'b0;
  logic        cpu_en;
  logic [1:0]  state;
  logic [1:0]  halt_cause;
  logic [15:0] retired;

  logic        reset2 = 1'b1;
  logic        cmd_valid2 = 1'b0;
  logic [1:0]  cmd_op2 = 2'd1;
  logic [3:0]  cmd_arg2 = '0;
  logic        cmd_ready2;
  logic [7:0]  pc2 = 8'h00;
  logic [7:0]  bp_addr2 = 8'hff;
  logic        bp_arm2 = 1'b0;
  logic        cpu_en2;
  logic [1:0]  state2;
  logic [1:0]  halt_cause2;
  logic [3:0]  retired2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  run_control #(.COUNT_W(16), .RUN_AT_RESET(1'b0)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_ready(cmd_ready), .pc(pc), .bp_addr(bp_addr), .bp_arm(bp_arm), .cpu_en(cpu_en),
    .state(state), .halt_cause(halt_cause), .retired(retired)
  );

  run_control #(.COUNT_W(4), .RUN_AT_RESET(1'b1)) dut_w4 (
    .clk(clk), .reset(reset2), .cmd_valid(cmd_valid2), .cmd_op(cmd_op2), .cmd_arg(cmd_arg2),
    .cmd_ready(cmd_ready2), .pc(pc2), .bp_addr(bp_addr2), .bp_arm(bp_arm2), .cpu_en(cpu_en2),
    .state(state2), .halt_cause(halt_cause2), .retired(retired2)
  );

  // Minimal CPU model: pc advances on every enabled cycle.
  always @(posedge clk) begin
    if (reset)       pc <= 8'h00;
    else if (cpu_en) pc <= pc + 8'd1;
  end

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic [15:0] arg;
    logic        en;
    logic [1:0]  st;
    logic [1:0]  cause;
    logic        rdy;
    logic [15:0] ret;
  } vec_t;

  localparam int NVEC = 32;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic v, input logic [1:0] op, input logic [15:0] arg,
                              input logic en, input logic [1:0] st, input logic [1:0] cause,
                              input logic rdy, input logic [15:0] ret);
    vec_t r;
    r.valid = v; r.op = op; r.arg = arg; r.en = en;
    r.st = st; r.cause = cause; r.rdy = rdy; r.ret = ret;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] arg);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'd1; cmd_arg = '0;
  endtask

  // Counts enabled cycles until the DUT reports HALTED; starts in the current cycle.
  task automatic run_until_halted(input int max, output int en_cycles, output bit ok);
    int i;
    en_cycles = 0; ok = 1'b0; i = 0;
    while (!ok && i < max) begin
      #1;
      if (state == 2'd0) ok = 1'b1;
      else begin
        if (cpu_en) en_cycles++;
        @(negedge clk);
        i++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  en_n;
    bit  ok;
    logic [15:0] ret0;

    // cycle-accurate table: inputs applied in cycle i, outputs expected in that same cycle
    vecs[0]  = mk(0, 1, 0, 0, 0, 0, 1, 0);
    vecs[1]  = mk(1, 2, 0, 0, 0, 0, 1, 0);
    vecs[2]  = mk(0, 1, 0, 1, 2, 0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 0, 0, 2, 1, 1);
    vecs[4]  = mk(1, 2, 0, 0, 0, 2, 1, 1);
    vecs[5]  = mk(0, 1, 0, 1, 2, 2, 0, 1);
    vecs[6]  = mk(1, 2, 0, 0, 0, 2, 1, 2);
    vecs[7]  = mk(0, 1, 0, 1, 2, 2, 0, 2);
    vecs[8]  = mk(0, 1, 0, 0, 0, 2, 1, 3);
    vecs[9]  = mk(1, 3, 5, 0, 0, 2, 1, 3);
    vecs[10] = mk(0, 1, 0, 1, 2, 2, 0, 3);
    vecs[11] = mk(0, 1, 0, 1, 2, 2, 0, 4);
    vecs[12] = mk(0, 1, 0, 1, 2, 2, 0, 5);
    vecs[13] = mk(0, 1, 0, 1, 2, 2, 0, 6);
    vecs[14] = mk(0, 1, 0, 1, 2, 2, 0, 7);
    vecs[15] = mk(0, 1, 0, 0, 0, 2, 1, 8);
    vecs[16] = mk(1, 1, 0, 0, 0, 2, 1, 8);
    vecs[17] = mk(1, 1, 0, 1, 1, 2, 0, 8);
    vecs[18] = mk(0, 1, 0, 1, 1, 2, 0, 9);
    vecs[19] = mk(1, 0, 0, 1, 1, 2, 1, 10);
    vecs[20] = mk(0, 1, 0, 0, 0, 1, 1, 11);
    vecs[21] = mk(1, 3, 2, 0, 0, 1, 1, 11);
    vecs[22] = mk(0, 1, 0, 1, 2, 1, 0, 11);
    vecs[23] = mk(1, 0, 0, 1, 2, 1, 1, 12);
    vecs[24] = mk(0, 1, 0, 0, 0, 2, 1, 13);
    vecs[25] = mk(1, 3, 3, 0, 0, 2, 1, 13);
    vecs[26] = mk(1, 0, 0, 1, 2, 2, 1, 13);
    vecs[27] = mk(0, 1, 0, 0, 0, 1, 1, 14);
    vecs[28] = mk(1, 3, 0, 0, 0, 1, 1, 14);
    vecs[29] = mk(0, 1, 0, 0, 0, 2, 1, 14);
    vecs[30] = mk(1, 0, 0, 0, 0, 2, 1, 14);
    vecs[31] = mk(0, 1, 0, 0, 0, 2, 1, 14);

    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      cmd_valid = vecs[i].valid; cmd_op = vecs[i].op; cmd_arg = vecs[i].arg;
      #1;
      chk($sformatf("v%0d cpu_en", i),     32'(cpu_en),     32'(vecs[i].en));
      chk($sformatf("v%0d state", i),      32'(state),      32'(vecs[i].st));
      chk($sformatf("v%0d halt_cause", i), 32'(halt_cause), 32'(vecs[i].cause));
      chk($sformatf("v%0d cmd_ready", i),  32'(cmd_ready),  32'(vecs[i].rdy));
      chk($sformatf("v%0d retired", i),    32'(retired),    32'(vecs[i].ret));
    end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'd1; cmd_arg = '0;

`ifdef BREAKPOINT_EN
    do_reset();
    bp_arm = 1'b1; bp_addr = 8'h04;
    issue(2'd1, 16'd0);
    run_until_halted(50, en_n, ok);
    chk("bp run timeout", 32'(ok), 32'd1);
    chk("bp run en cycles", 32'(en_n), 32'd4);
    chk("bp run pc", 32'(pc), 32'h04);
    chk("bp run cause", 32'(halt_cause), 32'd3);
    chk("bp run retired", 32'(retired), 32'd4);

    issue(2'd2, 16'd0);
    run_until_halted(20, en_n, ok);
    chk("bp step timeout", 32'(ok), 32'd1);
    chk("bp step en cycles", 32'(en_n), 32'd1);
    chk("bp step pc", 32'(pc), 32'h05);
    chk("bp step cause", 32'(halt_cause), 32'd2);

    bp_addr = 8'h08;
    issue(2'd3, 16'd10);
    run_until_halted(50, en_n, ok);
    chk("bp run_n timeout", 32'(ok), 32'd1);
    chk("bp run_n en cycles", 32'(en_n), 32'd3);
    chk("bp run_n cause", 32'(halt_cause), 32'd3);
    chk("bp run_n retired", 32'(retired), 32'd8);

    issue(2'd2, 16'd0);
    run_until_halted(20, en_n, ok);
    chk("bp step2 timeout", 32'(ok), 32'd1);
    chk("bp step2 en cycles", 32'(en_n), 32'd1);
    chk("bp step2 pc", 32'(pc), 32'h09);
    chk("bp step2 retired", 32'(retired), 32'd9);
`else
    do_reset();
    bp_arm = 1'b1; bp_addr = 8'h04;
    issue(2'd3, 16'd6);
    run_until_halted(50, en_n, ok);
    chk("nobp timeout", 32'(ok), 32'd1);
    chk("nobp en cycles", 32'(en_n), 32'd6);
    chk("nobp pc", 32'(pc), 32'h06);
    chk("nobp cause", 32'(halt_cause), 32'd2);
`endif
    bp_arm = 1'b0;

    // reset while counting reloads everything and holds cpu_en low
    issue(2'd3, 16'd10);
    #1;
    chk("rst counting state", 32'(state), 32'd2);
    ret0 = retired;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst cpu_en low", 32'(cpu_en), 32'd0);
    @(negedge clk);
    #1;
    chk("rst state", 32'(state), 32'd0);
    chk("rst retired", 32'(retired), 32'd0);
    chk("rst cause", 32'(halt_cause), 32'd0);
    chk("rst cpu_en held", 32'(cpu_en), 32'd0);
    chk("rst retired moved", 32'(ret0 != 16'd0), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post rst state", 32'(state), 32'd0);
    chk("post rst cpu_en", 32'(cpu_en), 32'd0);

    // narrow counter, running from reset: 17 enabled cycles wrap to 1
    @(negedge clk);
    reset2 = 1'b1;
    @(negedge clk);
    #1;
    chk("w4 reset state", 32'(state2), 32'd1);
    chk("w4 reset retired", 32'(retired2), 32'd0);
    chk("w4 reset cpu_en", 32'(cpu_en2), 32'd0);
    reset2 = 1'b0;
    repeat (17) @(negedge clk);
    #1;
    chk("w4 wrap retired", 32'(retired2), 32'd1);
    chk("w4 cpu_en", 32'(cpu_en2), 32'd1);
    chk("w4 cmd_ready", 32'(cmd_ready2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
